serial_byte_rx: RTL
===================

// Module: serial_byte_rx
// PURPOSE
//  Serial-to-parallel receiver: the far end of the shift8bit serial link, which sends MSB first.
//  - Samples one bit of si per en strobe and assembles WIDTH-bit words.
//  - Frame alignment comes from a sync pulse.
//  - Completed words are presented on a valid/ready parallel port, with sticky overrun detection.
// PARAMETERS
//  WIDTH      8  bits per word (>=2)
//  MSB_FIRST  1  1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//  clk          in   1      rising-edge clock
//  clr          in   1      asynchronous, active-high reset
//  en           in   1      bit strobe; si sampled on a clk edge where en=1
//  si           in   1      serial data in
//  sync         in   1      frame start; current bit becomes bit 0 of a new word
//  dout         out  WIDTH  received word (holding register)
//  dout_valid   out  1      dout holds an unconsumed word
//  dout_ready   in   1      consumer accepts dout when dout_valid & dout_ready
//  overrun      out  1      sticky; a completed word was dropped
//  overrun_clr  in   1      synchronous clear of overrun
//  bit_cnt      out  $clog2(WIDTH)  bits captured in current frame
// BEHAVIOUR
//  Reset (clr=1, async)
//  - state=HUNT; shift reg, bit_cnt, dout, dout_valid and overrun all 0.
//  FSM: HUNT, SHIFT
//  - HUNT: en ignored until sync=1.
//    - sync&en: capture si as bit 0, bit_cnt=1, go to SHIFT.
//    - sync&!en: bit_cnt=0, go to SHIFT.
//  - SHIFT, en=1, not last bit: shift si in, bit_cnt++.
//    - MSB_FIRST=1: sh <= {sh[W-2:0],si}; MSB_FIRST=0: sh <= {si,sh[W-1:1]}.
//  - SHIFT, en=1, bit_cnt==WIDTH-1 (last bit):
//    - Word completes; assembled word = shifted value including this si.
//    - bit_cnt wraps to 0; stay in SHIFT, so back-to-back words need no new sync.
//  - sync in SHIFT realigns: shift reg and bit_cnt cleared; same rules as in HUNT.
//    - A partial word is discarded silently; it does not count as overrun.
//  Word delivery
//  - On the completing edge, if holding register free or consumed this cycle (valid&ready):
//    - dout <= word; dout_valid=1 after the edge.
//    - Latency: last bit edge -> valid visible the same edge (0 extra cycles).
//  - If dout_valid=1 and dout_ready=0 on the completing edge:
//    - new word dropped; dout unchanged; overrun <= 1.
//  - valid&ready with no completion: dout_valid <= 0; dout holds its last value.
//  - dout stays stable while dout_valid=1 and not accepted.
//  Overrun
//  - overrun_clr clears overrun. If a new overrun occurs on the same edge, set wins.
//  Other rules
//  - en=0: no state change except the handshake.
//  - clr asserted mid-frame: immediate return to reset values; a pending dout is lost.
// STRUCTURE
//  Package serial_link_pkg holds:
//  - rx_state_t enum {HUNT, SHIFT} and the default WIDTH localparam (8).
//  - The MSB_FIRST default, shared with the transmitter side.
//  Sub-module rx_shift_core (shift reg + bit counter + completion flag):
//  - inputs: en, si, sync, MSB_FIRST.
//  - outputs: word, done pulse.
//  The top level keeps the FSM, holding register, handshake and overrun logic.
// TESTING
//  1. Reset, sync, then 8 en strobes carrying bits 1,0,1,0,0,1,0,1 with ready=1
//     -> dout=8'hA5, dout_valid for 1 cycle, overrun=0.
//  2. Two back-to-back words 8'h3C then 8'hC3 with no second sync, ready held 0 until after the 2nd
//     -> dout stays 8'h3C, overrun=1; pulse overrun_clr -> overrun=0.
//  3. Word completes on the same edge that the prior word is accepted (valid&ready)
//     -> dout=new word, dout_valid stays 1, overrun=0.
//  4. sync after 5 bits of a frame, then 8 bits of 8'h81
//     -> dout=8'h81, no overrun, partial word never appears.
//  5. clr asserted asynchronously between edges, mid-frame, with dout_valid=1
//     -> all outputs 0 at once; en ignored until next sync.
//  6. MSB_FIRST=0, bit sequence 1,0,1,0,0,1,0,1
//     -> dout=8'hA5 with first bit in dout[0].

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial byte link (transmitter and receiver sides).
package serial_link_pkg;
   typedef enum logic {HUNT, SHIFT} rx_state_t;
   localparam int WIDTH_DEF     = 8;
   localparam bit MSB_FIRST_DEF = 1'b1;
endpackage

// File: rtl/rx_shift_core.sv
// Shift register and bit counter for the receiver; flags the edge that completes a word.
module rx_shift_core #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic             en,
   input  logic             si,
   input  logic             sync,
   output logic [WIDTH-1:0] word,
   output logic             done,
   output logic [CW-1:0]    bit_cnt
);
   logic [WIDTH-1:0] sh, base;
   logic             last;

   // sync starts from an empty register so the current bit becomes bit 0
   assign base = sync ? '0 : sh;
   assign word = MSB_FIRST ? {base[WIDTH-2:0], si} : {si, base[WIDTH-1:1]};
   assign last = (bit_cnt == CW'(WIDTH-1));
   assign done = run & en & ~sync & last;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sh      <= '0;
         bit_cnt <= '0;
      end else if (sync) begin
         sh      <= en ? word : '0;
         bit_cnt <= en ? CW'(1) : '0;
      end else if (run && en) begin
         sh      <= word;
         bit_cnt <= last ? '0 : bit_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel receiver: frames WIDTH-bit words from a strobed bit stream and
// presents them on a valid/ready port with sticky overrun detection.
module serial_byte_rx
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     si,
   input  logic                     sync,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     overrun,
   input  logic                     overrun_clr,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);
   rx_state_t        state;
   logic [WIDTH-1:0] word;
   logic             done, accept, room;

   rx_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
      .clk     (clk),
      .clr     (clr),
      .run     (state == SHIFT),
      .en      (en),
      .si      (si),
      .sync    (sync),
      .word    (word),
      .done    (done),
      .bit_cnt (bit_cnt)
   );

   assign accept = dout_valid & dout_ready;
   assign room   = ~dout_valid | dout_ready;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= HUNT;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (sync) state <= SHIFT;
         if (done && room) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (accept) begin
            dout_valid <= 1'b0;
         end
         // a fresh drop on the clearing edge must stay visible
         if (done && !room)    overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end
endmodule
